// File: rtl/alu_mult_ctrl.sv
// ---------------------------------------------------------------------------
// alu_mult_ctrl
// Iterative 16x16->32 shift-and-add multiplier sequencer. It owns no adder of
// its own: every add and negate goes through an external ALU driven on the
// alu_* ports. Signed operands are converted to magnitudes through the ALU
// before the iterations and the result is negated afterwards when needed.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start, signed_i     request (sampled in IDLE) and operand signedness
//   a_i, b_i            16-bit multiplicand / multiplier, captured with start
//   busy, done, prod    handshake back to decode/execute; prod held until next done
//   alu_a .. alu_sign   combinational drive of the borrowed ALU
//   alu_out, alu_ofl    ALU result and carry-out (alu_sign=0 makes Ofl the carry)
//   alu_z               ALU zero flag, not needed here
// ---------------------------------------------------------------------------
module alu_mult_ctrl #(
    parameter int unsigned ITER = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic        busy,
    output logic        done,
    output logic [31:0] prod,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_cin,
    output logic        alu_inva,
    output logic        alu_invb,
    output logic        alu_sign,
    input  logic [15:0] alu_out,
    input  logic        alu_ofl,
    input  logic        alu_z
);

    localparam int unsigned W      = 16;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
    localparam logic [2:0]       OP_ADD   = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_NEG_A  = 3'd1,
        S_NEG_B  = 3'd2,
        S_ITER   = 3'd3,
        S_NEG_LO = 3'd4,
        S_NEG_HI = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     m_q, m_d;
    logic [W-1:0]     p_hi_q, p_hi_d;
    logic [W-1:0]     p_lo_q, p_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2*W-1:0]   prod_q, prod_d;

    logic unused_alu_z;
    assign unused_alu_z = alu_z;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = signed_i ? S_NEG_A : S_ITER;
            S_NEG_A:  state_d = S_NEG_B;
            S_NEG_B:  state_d = S_ITER;
            S_ITER:   if (cnt_q == CNT_LAST) state_d = neg_q ? S_NEG_LO : S_DONE;
            S_NEG_LO: state_d = S_NEG_HI;
            S_NEG_HI: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ALU drive; every negate is ~x + 1 (or + carry for the upper half)
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_cin  = 1'b0;
        alu_inva = 1'b0;
        alu_op   = OP_ADD;
        alu_invb = 1'b0;
        alu_sign = 1'b0;
        case (state_q)
            S_NEG_A: begin
                alu_a    = m_q;
                alu_inva = 1'b1;
                alu_cin  = 1'b1;
            end
            S_NEG_B: begin
                alu_a    = p_lo_q;
                alu_inva = 1'b1;
                alu_cin  = 1'b1;
            end
            S_ITER: begin
                alu_a = p_hi_q;
                alu_b = p_lo_q[0] ? m_q : '0;
            end
            S_NEG_LO: begin
                alu_a    = p_lo_q;
                alu_inva = 1'b1;
                alu_cin  = 1'b1;
            end
            S_NEG_HI: begin
                alu_a    = p_hi_q;
                alu_inva = 1'b1;
                alu_cin  = carry_q;
            end
            default: ;
        endcase
    end

    // Datapath and registered handshake outputs
    always_comb begin
        m_d     = m_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = a_i;
                    p_lo_d  = b_i;
                    p_hi_d  = '0;
                    cnt_d   = '0;
                    neg_d   = signed_i & (a_i[W-1] ^ b_i[W-1]);
                    carry_d = 1'b0;
                end
            end
            // Only negative operands take the negated value; 0x8000 stays 0x8000,
            // which is already its unsigned magnitude.
            S_NEG_A:  if (m_q[W-1]) m_d = alu_out;
            S_NEG_B:  if (p_lo_q[W-1]) p_lo_d = alu_out;
            S_ITER: begin
                {p_hi_d, p_lo_d} = {alu_ofl, alu_out, p_lo_q[W-1:1]};
                cnt_d            = cnt_q + CNT_W'(1);
            end
            S_NEG_LO: begin
                p_lo_d  = alu_out;
                carry_d = alu_ofl;
            end
            S_NEG_HI: p_hi_d = alu_out;
            default: ;
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
        prod_d = (state_d == S_DONE) ? {p_hi_d, p_lo_d} : prod_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q     <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            m_q     <= m_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign prod = prod_q;

endmodule

// File: tb/tb_alu_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_mult_ctrl
// Drives alu_mult_ctrl wired to a behavioural ALU. A driver issues operations
// and pushes the expected product and latency into a queue; an independent
// monitor on the falling edge pops on done and also checks busy, prod hold and
// the idle ALU drive every cycle.
// ---------------------------------------------------------------------------
module tb_alu_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_i;
    logic [15:0] a_i, b_i;
    logic        busy, done;
    logic [31:0] prod;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_op;
    logic        alu_cin, alu_inva, alu_invb, alu_sign, alu_ofl, alu_z;

    always #5 clk = ~clk;

    alu_mult_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .signed_i (signed_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy     (busy),
        .done     (done),
        .prod     (prod),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_cin  (alu_cin),
        .alu_inva (alu_inva),
        .alu_invb (alu_invb),
        .alu_sign (alu_sign),
        .alu_out  (alu_out),
        .alu_ofl  (alu_ofl),
        .alu_z    (alu_z)
    );

    // Behavioural ALU: add with optional operand inversion and carry-in
    logic [16:0] alu_sum;
    assign alu_sum = {1'b0, (alu_inva ? ~alu_a : alu_a)}
                   + {1'b0, (alu_invb ? ~alu_b : alu_b)}
                   + 17'(alu_cin);
    assign alu_out = alu_sum[15:0];
    assign alu_ofl = alu_sum[16];
    assign alu_z   = (alu_sum[15:0] == 16'h0000);

    typedef struct {
        logic [31:0] prod;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] last_prod;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                             input logic s);
        longint pa, pb;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        return 32'(pa * pb);
    endfunction

    function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b, input logic s);
        if (!s) return 17;
        return ((a[15] != b[15]) ? 21 : 19);
    endfunction

    // Monitor: scoreboard pop on done, per-cycle handshake and ALU checks
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("alu_op", 32'(alu_op), 32'd4);
            chk("alu_invb", 32'(alu_invb), 32'd0);
            chk("alu_sign", 32'(alu_sign), 32'd0);
            if (done) begin
                chk("busy_at_done", 32'(busy), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("prod", prod, e.prod);
                    chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                    last_prod = e.prod;
                end
            end else begin
                chk("busy", 32'(busy), (exp_q.size() != 0) ? 32'd1 : 32'd0);
                chk("prod_hold", prod, last_prod);
            end
            if (done || exp_q.size() == 0) begin
                chk("idle_alu_drive", {alu_a, alu_b}, 32'h0);
                chk("idle_alu_ctl", {30'h0, alu_cin, alu_inva}, 32'h0);
            end
        end
    end

    // Call at a falling edge with the DUT in IDLE for the next rising edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
        exp_t e;
        start    = 1'b1;
        a_i      = a;
        b_i      = b;
        signed_i = s;
        e.prod      = ref_prod(a, b, s);
        e.lat       = ref_lat(a, b, s);
        e.start_cyc = cyc;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        start    = 1'b0;
        a_i      = $urandom_range(0, 16'hFFFF);
        b_i      = $urandom_range(0, 16'hFFFF);
        signed_i = $urandom_range(0, 1);
    endtask

    // Returns at the falling edge where done is high.
    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        issue(a, b, s);
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        signed_i  = 1'b0;
        a_i       = '0;
        b_i       = '0;
        last_prod = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_prod", prod, 32'd0);
        mon_en = 1'b1;

        // Directed corners
        run_op(16'd3,    16'd5,    1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0);
        run_op(16'hFFFD, 16'd5,    1'b1);
        run_op(16'h8000, 16'h8000, 1'b1);
        run_op(16'hFFFF, 16'h0000, 1'b1);
        run_op(16'h7FFF, 16'h8000, 1'b1);
        run_op(16'h0000, 16'hFFFF, 1'b0);

        // Start during an operation is ignored
        issue(16'd1234, 16'd77, 1'b0);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        a_i      = 16'hAAAA;
        b_i      = 16'h5555;
        signed_i = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        @(negedge clk);

        // Back-to-back: start raised in the done cycle, taken in the following IDLE
        issue(16'd100, 16'd200, 1'b0);
        wait_done();
        start    = 1'b1;
        a_i      = 16'hFFF0;
        b_i      = 16'h0010;
        signed_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        issue(16'hFFF0, 16'h0010, 1'b1);
        wait_done();
        @(negedge clk);

        // Reset in the middle of the iterations, then a fresh operation
        issue(16'd9, 16'd9, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        last_prod = '0;
        @(negedge clk);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_prod", prod, 32'd0);
        run_op(16'd2, 16'd2, 1'b0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 6 == 0) ra = 16'h8000;
            run_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
